// File: rtl/bpred_ram_pkg.sv
// ============================================================================
// Module   : bpred_ram_pkg
// Purpose  : Shared widths and BTB word field positions for predictor RAMs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bpred_ram_pkg;

   localparam int BTB_DATA_W   = 36;
   localparam int INSN_DATA_W  = 32;
   localparam int BPRED_ADDR_W = 8;
   localparam int BTB_BE_W     = 4;

   // BTB word layout; the carry field deliberately overlaps the low target bits.
   localparam int BTB_TARGET_MSB  = 35;
   localparam int BTB_TARGET_LSB  = 6;
   localparam int BTB_BIMODAL_MSB = 5;
   localparam int BTB_BIMODAL_LSB = 4;
   localparam int BTB_CARRY_MSB   = 8;
   localparam int BTB_CARRY_LSB   = 6;

   function automatic int lane_width(input int data_w, input int be_w);
      return data_w / be_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bpred_ram_lane.sv
// ============================================================================
// Module   : bpred_ram_lane
// Purpose  : LANE_W x 2**ADDR_W storage for one byte lane, own write enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpred_ram_lane
   import bpred_ram_pkg::*;
#(
   parameter int LANE_W = lane_width(BTB_DATA_W, BTB_BE_W),
   parameter int ADDR_W = BPRED_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wraddress,
   input  logic [LANE_W-1:0] data,
   input  logic [ADDR_W-1:0] rdaddress,
   output logic [LANE_W-1:0] rd_data
);

   logic [LANE_W-1:0] r_mem [0:(2**ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[wraddress] <= data;
      end
   end

   // The output register lives in the parent so the bypass mux can sit in front of it.
   assign rd_data = r_mem[rdaddress];

endmodule

`default_nettype wire

// File: rtl/bpred_sdp_ram.sv
// ============================================================================
// Module   : bpred_sdp_ram
// Purpose  : Simple dual-port RAM with per-lane byte enables, 1-cycle read.
//            Define DPRAM_WR_BYPASS_EN for new-data read-during-write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpred_sdp_ram
   import bpred_ram_pkg::*;
#(
   parameter int DATA_W = BTB_DATA_W,
   parameter int ADDR_W = BPRED_ADDR_W,
   parameter int BE_W   = BTB_BE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wren,
   input  logic [ADDR_W-1:0] wraddress,
   input  logic [DATA_W-1:0] data,
   input  logic [BE_W-1:0]   byteena,
   input  logic [ADDR_W-1:0] rdaddress,
   output logic [DATA_W-1:0] q
);

   localparam int LANE_W = lane_width(DATA_W, BE_W);

   logic [DATA_W-1:0] w_rd_word;
   logic [DATA_W-1:0] r_q;

`ifdef DPRAM_WR_BYPASS_EN
   logic w_same_addr;
   assign w_same_addr = wren && (wraddress == rdaddress);
`endif

   generate
      for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
         logic [LANE_W-1:0] w_lane_rd;

         bpred_ram_lane #(
            .LANE_W (LANE_W),
            .ADDR_W (ADDR_W)
         ) u_lane (
            .clk       (clk),
            .we        (wren & byteena[gi]),
            .wraddress (wraddress),
            .data      (data[gi*LANE_W +: LANE_W]),
            .rdaddress (rdaddress),
            .rd_data   (w_lane_rd)
         );

`ifdef DPRAM_WR_BYPASS_EN
         // Enabled lanes of a colliding write forward the incoming data.
         assign w_rd_word[gi*LANE_W +: LANE_W] =
            (w_same_addr && byteena[gi]) ? data[gi*LANE_W +: LANE_W] : w_lane_rd;
`else
         assign w_rd_word[gi*LANE_W +: LANE_W] = w_lane_rd;
`endif
      end
   endgenerate

   // Reset clears only the output register; writes proceed during reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else begin
         r_q <= w_rd_word;
      end
   end

   assign q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_bpred_sdp_ram.sv
// ============================================================================
// Module   : tb_bpred_sdp_ram
// Purpose  : Scoreboard bench for bpred_sdp_ram (both bypass builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bpred_sdp_ram;

   localparam int DW = 36;
   localparam int AW = 8;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          wren;
   logic [AW-1:0] wraddress;
   logic [DW-1:0] data;
   logic [BW-1:0] byteena;
   logic [AW-1:0] rdaddress;
   logic [DW-1:0] q;

   bpred_sdp_ram #(.DATA_W(DW), .ADDR_W(AW), .BE_W(BW)) dut (
      .clk       (clk),
      .reset     (reset),
      .wren      (wren),
      .wraddress (wraddress),
      .data      (data),
      .byteena   (byteena),
      .rdaddress (rdaddress),
      .q         (q)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic [DW-1:0] val;
      string         name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   // Monitor: every expectation is tagged with the posedge that should produce it.
   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_chk++;
         if (e.cyc != cyc)
            $display("FAIL %s: expected q=%h at cycle %0d, not sampled (now %0d)",
                     e.name, e.val, e.cyc, cyc);
         else if (q !== e.val)
            $display("FAIL %s: q=%h required %h (cycle %0d)", e.name, q, e.val, cyc);
         else
            n_pass++;
      end
   end

   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, input logic [AW-1:0] ra);
      @(negedge clk);
      wren      = we;
      wraddress = wa;
      data      = d;
      byteena   = be;
      rdaddress = ra;
   endtask

   task automatic expect_next(input logic [DW-1:0] v, input string nm);
      sb.push_back('{cyc + 1, v, nm});
   endtask

   initial begin
      reset     = 1'b1;
      wren      = 1'b0;
      wraddress = '0;
      data      = '0;
      byteena   = '0;
      rdaddress = 8'd5;

      // Reset sweep clears the array while q is held at zero.
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, i[AW-1:0], '0, 4'hF, 8'd5);
         if (i < 8) expect_next('0, "reset_q");
      end
      drive(1'b1, 8'd5, 36'h5A5A5A5A5, 4'hF, 8'd5);
      expect_next('0, "reset_hold_wr");
      drive(1'b0, 8'd0, '0, 4'h0, 8'd5);
      expect_next('0, "reset_hold");

      drive(1'b0, 8'd0, '0, 4'h0, 8'd5);
      reset = 1'b0;
      expect_next(36'h5A5A5A5A5, "post_reset");

      for (int a = 0; a < 256; a++) begin
         drive(1'b0, 8'd0, '0, 4'h0, a[AW-1:0]);
         expect_next((a == 5) ? 36'h5A5A5A5A5 : 36'h0, "sweep_rd");
      end

      // Full and partial lane writes on entry 0x10.
      drive(1'b1, 8'h10, 36'h123456789, 4'hF, 8'h00);
      drive(1'b0, 8'h00, '0, 4'h0, 8'h10);
      expect_next(36'h123456789, "full_write");
      drive(1'b1, 8'h10, 36'h0000001FF, 4'b0001, 8'h00);
      drive(1'b0, 8'h00, '0, 4'h0, 8'h10);
      expect_next(36'h1234567FF, "partial_lane0");
      drive(1'b1, 8'h10, 36'hFFFFFFFFF, 4'b0100, 8'h00);
      drive(1'b0, 8'h00, '0, 4'h0, 8'h10);
      expect_next(36'h127FD67FF, "partial_lane2");
      drive(1'b1, 8'h10, 36'h000000000, 4'b0000, 8'h10);
      expect_next(36'h127FD67FF, "be0_noop_a");
      drive(1'b0, 8'h00, '0, 4'h0, 8'h10);
      expect_next(36'h127FD67FF, "be0_noop_b");

      // Same-address read during write.
      drive(1'b1, 8'd3, 36'h0, 4'hF, 8'd0);
      drive(1'b1, 8'd3, 36'hABC, 4'hF, 8'd3);
`ifdef DPRAM_WR_BYPASS_EN
      expect_next(36'hABC, "rdw_full");
`else
      expect_next(36'h0, "rdw_full");
`endif
      drive(1'b0, 8'd0, '0, 4'h0, 8'd3);
      expect_next(36'hABC, "rdw_after");
      drive(1'b1, 8'd3, 36'hFFFFFFFFF, 4'b0001, 8'd3);
`ifdef DPRAM_WR_BYPASS_EN
      expect_next(36'hBFF, "rdw_partial");
`else
      expect_next(36'hABC, "rdw_partial");
`endif
      drive(1'b0, 8'd0, '0, 4'h0, 8'd3);
      expect_next(36'hBFF, "rdw_partial_after");

      // Address extremes, alternating reads with an unrelated concurrent write.
      drive(1'b1, 8'hFF, 36'hFEDCBA987, 4'hF, 8'd0);
      drive(1'b1, 8'h00, 36'h0F0F0F0F0, 4'hF, 8'd0);
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 8'h80, 36'h111111111 * (k + 1), 4'hF, (k % 2 == 0) ? 8'hFF : 8'h00);
         expect_next((k % 2 == 0) ? 36'hFEDCBA987 : 36'h0F0F0F0F0, "wrap_alt");
      end
      drive(1'b0, 8'd0, '0, 4'h0, 8'h80);
      expect_next(36'h666666666, "indep_wr");

      drive(1'b0, 8'd0, '0, 4'h0, 8'd0);
      for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         n_chk++;
         $display("FAIL drain: %0d expectations pending, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
